// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - 8-bit word serializer driving an external 8:1 mux (optional parity: SCAN_PARITY_EN)
module mux_scan_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       ser_data,
    output logic       ser_valid,
    output logic       ser_last,
    input  logic       ser_ready,
    output logic       busy
);

`ifdef SCAN_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    // First and final select index of a word, fixed by the scan direction.
    localparam logic [2:0] IDX_FIRST = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [2:0] IDX_LAST  = LSB_FIRST ? 3'd7 : 3'd0;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] idx_q, idx_d;

    assign mux_i = hold_q;
    assign mux_s = idx_q;

    // Next-state and output decode; the index only moves on an accepted bit.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        ser_data  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    hold_d  = in_data;
                    idx_d   = IDX_FIRST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = mux_y;
`ifdef SCAN_PARITY_EN
                ser_last  = 1'b0;
`else
                ser_last  = (idx_q == IDX_LAST);
`endif
                if (ser_ready) begin
                    if (idx_q == IDX_LAST) begin
`ifdef SCAN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else if (LSB_FIRST) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
`ifdef SCAN_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_data  = ^hold_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold and index registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb/tb_mux_scan_serializer.sv - checks LSB-first and MSB-first serializers side by side against a frame model
module tb_mux_scan_serializer;

`ifdef SCAN_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ser_ready = 1'b0;

    logic       a_in_ready, a_ser_data, a_ser_valid, a_ser_last, a_busy, a_mux_y;
    logic [7:0] a_mux_i;
    logic [2:0] a_mux_s;
    logic       b_in_ready, b_ser_data, b_ser_valid, b_ser_last, b_busy, b_mux_y;
    logic [7:0] b_mux_i;
    logic [2:0] b_mux_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign a_mux_y = a_mux_i[a_mux_s];
    assign b_mux_y = b_mux_i[b_mux_s];

    mux_scan_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .mux_i(a_mux_i), .mux_s(a_mux_s), .mux_y(a_mux_y), .ser_data(a_ser_data),
        .ser_valid(a_ser_valid), .ser_last(a_ser_last), .ser_ready(ser_ready), .busy(a_busy)
    );

    mux_scan_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .mux_i(b_mux_i), .mux_s(b_mux_s), .mux_y(b_mux_y), .ser_data(b_ser_data),
        .ser_valid(b_ser_valid), .ser_last(b_ser_last), .ser_ready(ser_ready), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bit k of word w: data bits in scan order, then the even-parity bit.
    function automatic logic exp_bit(input logic [7:0] w, input int k, input bit lsb);
        if (k >= 8) return ^w;
        return lsb ? w[k] : w[7 - k];
    endfunction

    function automatic logic [2:0] exp_sel(input int k, input bit lsb);
        int s;
        s = (k >= 8) ? (lsb ? 7 : 0) : (lsb ? k : 7 - k);
        return 3'(s);
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_lsb_in_ready"}, 32'(a_in_ready), 32'd1);
        chk({tag, "_lsb_ser_valid"}, 32'(a_ser_valid), 32'd0);
        chk({tag, "_lsb_ser_last"}, 32'(a_ser_last), 32'd0);
        chk({tag, "_lsb_busy"}, 32'(a_busy), 32'd0);
        chk({tag, "_msb_in_ready"}, 32'(b_in_ready), 32'd1);
        chk({tag, "_msb_ser_valid"}, 32'(b_ser_valid), 32'd0);
        chk({tag, "_msb_ser_last"}, 32'(b_ser_last), 32'd0);
        chk({tag, "_msb_busy"}, 32'(b_busy), 32'd0);
    endtask

    // mode 0: always ready; 1: random ready; 2: three stall cycles at bit index 2.
    // abort_at >= 0 asserts rst together with a ready handshake at that bit.
    task automatic send_word(input logic [7:0] w, input int mode, input int abort_at);
        int k, cyc, stall;
        logic rdy;
        k = 0; cyc = 0; stall = 0;
        @(negedge clk);
        chk("load_lsb_in_ready", 32'(a_in_ready), 32'd1);
        chk("load_msb_in_ready", 32'(b_in_ready), 32'd1);
        in_data = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (k < NBITS && cyc < 200) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else if (k == 2 && stall < 3) begin rdy = 1'b0; stall++; end
            else rdy = 1'b1;
            ser_ready = rdy;
            chk("lsb_ser_valid", 32'(a_ser_valid), 32'd1);
            chk("lsb_in_ready", 32'(a_in_ready), 32'd0);
            chk("lsb_busy", 32'(a_busy), 32'd1);
            chk("lsb_ser_data", 32'(a_ser_data), 32'(exp_bit(w, k, 1'b1)));
            chk("lsb_ser_last", 32'(a_ser_last), 32'(k == NBITS - 1));
            chk("lsb_mux_s", 32'(a_mux_s), 32'(exp_sel(k, 1'b1)));
            chk("lsb_mux_i", 32'(a_mux_i), 32'(w));
            chk("msb_ser_valid", 32'(b_ser_valid), 32'd1);
            chk("msb_in_ready", 32'(b_in_ready), 32'd0);
            chk("msb_busy", 32'(b_busy), 32'd1);
            chk("msb_ser_data", 32'(b_ser_data), 32'(exp_bit(w, k, 1'b0)));
            chk("msb_ser_last", 32'(b_ser_last), 32'(k == NBITS - 1));
            chk("msb_mux_s", 32'(b_mux_s), 32'(exp_sel(k, 1'b0)));
            chk("msb_mux_i", 32'(b_mux_i), 32'(w));
            if (k == abort_at) rst = 1'b1;
            @(negedge clk);
            cyc++;
            if (rst) begin
                rst = 1'b0;
                in_valid = 1'b0;
                chk_idle("abort");
                return;
            end
            if (rdy) k++;
        end
        in_valid = 1'b0;
        chk("frame_bound", 32'(cyc < 200), 32'd1);
        if (mode == 0) chk("frame_cycles", 32'(cyc), 32'(NBITS));
        chk_idle("end");
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hEE;
        ser_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk_idle("reset");
        chk("reset_lsb_mux_i", 32'(a_mux_i), 32'h00);
        chk("reset_lsb_mux_s", 32'(a_mux_s), 32'd0);
        chk("reset_msb_mux_i", 32'(b_mux_i), 32'h00);
        chk("reset_msb_mux_s", 32'(b_mux_s), 32'd0);

        send_word(8'hA5, 0, -1);
        send_word(8'h81, 0, -1);
        send_word(8'h3C, 2, -1);
        send_word(8'h00, 0, -1);
        send_word(8'h5A, 0, 4);
        send_word(8'h0F, 0, -1);
        send_word(8'h07, 0, -1);
        send_word(8'h03, 0, -1);
        for (int i = 0; i < 20; i++) begin
            send_word(8'($urandom), 1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 The block SHALL have one parameter: LSB_FIRST, default 1; 1 means select indices run 0..7, 0 means they run 7..0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, 8 bits: the parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port mux_i, output, 8 bits: the held word, driven to the 8:1 mux data inputs.
REQ-008 The block SHALL have port mux_s, output, 3 bits: the bit index, driven to the 8:1 mux select.
REQ-009 The block SHALL have port mux_y, input, 1 bit: the 8:1 mux output, sampled combinationally.
REQ-010 The block SHALL have port ser_data, output, 1 bit: the serial bit.
REQ-011 The block SHALL have port ser_valid, output, 1 bit: ser_data is valid.
REQ-012 The block SHALL have port ser_last, output, 1 bit: the current bit is the final bit of the word.
REQ-013 The block SHALL have port ser_ready, input, 1 bit: the consumer accepts ser_data.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, SHIFT and, only when the Configuration macro is defined, PARITY.
REQ-016 In IDLE, outputs SHALL be: in_ready=1, ser_valid=0, ser_last=0, busy=0.
REQ-017 In IDLE, an in_valid&&in_ready cycle SHALL load in_data into the hold register, set the index to 0 (LSB_FIRST=1) or 7 (LSB_FIRST=0), and move to SHIFT.
REQ-018 mux_i SHALL equal the hold register at all times.
REQ-019 mux_s SHALL equal the index register at all times.
REQ-020 In SHIFT, outputs SHALL be: ser_valid=1, in_ready=0, ser_data=mux_y.
REQ-021 In SHIFT, in_valid SHALL be ignored.
REQ-022 A bit SHALL transfer only on a cycle with ser_valid&&ser_ready.
REQ-023 While ser_ready=0, the index, ser_data and ser_last SHALL hold stable.
REQ-024 On a transfer that is not the 8th bit, the index SHALL step by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0).
REQ-025 The 8th bit SHALL be the bit at index 7 (LSB_FIRST=1) or index 0 (LSB_FIRST=0).
REQ-026 The index SHALL never wrap within a word.
REQ-027 Without the Configuration macro, ser_last SHALL be 1 on the 8th bit, and a transfer of that bit SHALL return the block to IDLE.
REQ-028 in_ready SHALL rise the cycle after the final transfer, so there is no same-cycle reload and the minimum word period is 9 cycles.
REQ-029 Latency SHALL be 1 cycle: the first bit is valid the cycle after the load handshake.
REQ-030 An illegal state encoding SHALL go to IDLE on the next cycle.

Reset
REQ-031 When rst=1 at a clk edge, the block SHALL enter IDLE from any state, including mid-word, and discard the remaining bits.
REQ-032 After reset, hold register = 8'h00 and index = 3'd0.
REQ-033 After reset, outputs SHALL be: in_ready=1, ser_valid=0, ser_last=0, busy=0.
REQ-034 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-035 Macro SCAN_PARITY_EN SHALL enable parity.
REQ-036 With SCAN_PARITY_EN defined, the 8th-bit transfer SHALL move to PARITY instead of IDLE, with ser_last=0 on the 8th bit.
REQ-037 In PARITY, outputs SHALL be: ser_valid=1, ser_data = XOR of the hold register (even parity), ser_last=1.
REQ-038 In PARITY, a transfer SHALL return the block to IDLE, giving a 9-bit frame.
REQ-039 Without SCAN_PARITY_EN, the PARITY state and its logic SHALL be absent, giving an 8-bit frame.

Verification
REQ-040 Scenario, LSB_FIRST=1, ser_ready=1, load 8'hA5 -> ser_data 1,0,1,0,0,1,0,1; mux_s 0..7; ser_last only on bit 8; in_ready=1 on cycle 10.
REQ-041 Scenario, LSB_FIRST=0, load 8'h81 -> bits 1,0,0,0,0,0,0,1; mux_s 7..0.
REQ-042 Scenario, ser_ready held 0 for 3 cycles at bit 3 of 8'h3C -> mux_s=2 and ser_data=1 held stable; the stream resumes with no bit lost or duplicated.
REQ-043 Scenario, in_valid=1 with 8'hFF during SHIFT of 8'h00 -> all 8 bits are 0; in_ready=0; the new word is loaded only after return to IDLE.
REQ-044 Scenario, rst asserted at bit 5 of 8'h5A -> next cycle IDLE, ser_valid=0, busy=0; the next load of 8'h0F serializes from bit 0.
REQ-045 Scenario, SCAN_PARITY_EN defined, load 8'h07 -> 9 bits with parity bit 1 and ser_last only on bit 9; load 8'h03 -> parity bit 0.
